seg7_scan_mux: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It accepts N packed 4-bit digit codes plus per-digit decimal points, and scans one digit at a time at a programmable refresh rate. It adds tear-free frame-synchronous updates, leading-zero blanking and an anti-ghosting dead gap. It sits between the clock/counter datapath and the board display pins, and replaces per-digit combinational decoders.

---
 rtl/seg7_scan_mux_if.sv | 27 ++
 rtl/seg7_scan_mux.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Signal bundle between the display datapath and the 7-segment scanner.
// load is a plain level strobe: every cycle it is high, bcd_in/dp_in are captured.
interface seg7_scan_mux_if #(
  parameter int NDIGITS = 4
);
  localparam int SW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [4*NDIGITS-1:0] bcd_in;
  logic [NDIGITS-1:0]   dp_in;
  logic                 load;
  logic                 blank_lz;
  logic [6:0]           seg;
  logic                 dp;
  logic [NDIGITS-1:0]   an;
  logic [SW-1:0]        digit_sel;
  logic                 frame_tick;

  modport master (
    output bcd_in, dp_in, load, blank_lz,
    input  seg, dp, an, digit_sel, frame_tick
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz,
    output seg, dp, an, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous
// updates, leading-zero blanking and an all-off dead gap at the start of each slot.
module seg7_scan_mux #(
  parameter int NDIGITS       = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYCLES    = 1,
  parameter int AN_ACTIVE_LOW = 1
) (
  input logic            clk,
  input logic            reset,
  seg7_scan_mux_if.slave bus
);
  localparam int SW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]      CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]      IDX_LAST = SW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] AN_OFF   = {NDIGITS{AN_ACTIVE_LOW != 0}};

  logic [CW-1:0]        cnt;
  logic [SW-1:0]        idx;
  logic [4*NDIGITS-1:0] hold_bcd, disp_bcd;
  logic [NDIGITS-1:0]   hold_dp, disp_dp;
  logic                 slot_end, boundary, boundary_q;
  logic                 in_gap;
  logic [NDIGITS-1:0]   lz, an_hot;
  logic [3:0]           code;
  logic                 code_dp, code_blank;
  logic                 above_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    case (c)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam logic [CW-1:0] GAP_LIM = CW'(GAP_CYCLES);
      assign in_gap = (cnt < GAP_LIM);
    end else begin : g_no_gap
      assign in_gap = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      boundary_q <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      boundary_q <= boundary;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // disp only changes on the frame boundary so a scan never mixes old and new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_bcd <= '0;
      hold_dp  <= '0;
      disp_bcd <= '0;
      disp_dp  <= '0;
    end else begin
      if (bus.load) begin
        hold_bcd <= bus.bcd_in;
        hold_dp  <= bus.dp_in;
      end
      if (boundary) begin
        disp_bcd <= hold_bcd;
        disp_dp  <= hold_dp;
      end
    end
  end

  // lz[i]: digit i and everything above it are zero; digit 0 is never a candidate.
  always_comb begin
    lz         = '0;
    above_zero = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero && (disp_bcd[4*i +: 4] == 4'h0);
      lz[i]      = above_zero;
    end
  end

  always_comb begin
    code       = 4'h0;
    code_dp    = 1'b0;
    code_blank = 1'b0;
    an_hot     = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == SW'(i)) begin
        code       = disp_bcd[4*i +: 4];
        code_dp    = disp_dp[i];
        code_blank = lz[i];
        an_hot[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.an         <= AN_OFF;
      bus.digit_sel  <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.digit_sel  <= idx;
      bus.frame_tick <= boundary_q;
      if (in_gap) begin
        bus.seg <= 7'h7F;
        bus.dp  <= 1'b1;
        bus.an  <= AN_OFF;
      end else begin
        bus.seg <= (bus.blank_lz && code_blank) ? 7'h7F : seg_decode(code);
        bus.dp  <= ~code_dp;
        bus.an  <= (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: per-cycle expected outputs of each frame
// are queued from a reference model and popped against the sampled DUT outputs.
module tb_seg7_scan_mux;
  localparam int N   = 4;
  localparam int RD  = 4;
  localparam int GAP = 1;
  localparam int FL  = N * RD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [14:0] exp_q[$];

  seg7_scan_mux_if #(.NDIGITS(N)) bus();

  seg7_scan_mux #(
    .NDIGITS(N), .REFRESH_DIV(RD), .GAP_CYCLES(GAP), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] tab [16];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tab[d];
  endfunction

  function automatic logic [14:0] got_vec();
    return {bus.an, bus.seg, bus.dp, bus.digit_sel, bus.frame_tick};
  endfunction

  // Expected {an, seg, dp, digit_sel, frame_tick} for each cycle of one frame.
  task automatic push_frame(input logic [15:0] cur_bcd, input logic [3:0] cur_dp,
                            input bit blz, input bit ft0);
    for (int c = 0; c < FL; c++) begin
      int slot, sub;
      logic [3:0] an_e, d;
      logic [6:0] seg_e;
      logic dp_e, blank;
      slot  = c / RD;
      sub   = c % RD;
      d     = 4'((cur_bcd >> (4 * slot)) & 16'hF);
      blank = blz && (slot != 0) && ((cur_bcd >> (4 * slot)) == 16'h0);
      if (sub < GAP) begin
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
      end else begin
        an_e  = ~(4'b0001 << slot);
        seg_e = blank ? 7'h7F : ref_seg(d);
        dp_e  = ~cur_dp[slot];
      end
      exp_q.push_back({an_e, seg_e, dp_e, 2'(slot), (c == 0) ? ft0 : 1'b0});
    end
  endtask

  task automatic report_fail(input string name, input int c,
                             input logic [14:0] g, input logic [14:0] e);
    $display("FAIL %s c=%0d an=%b exp %b seg=%b exp %b dp=%b exp %b sel=%0d exp %0d ft=%b exp %b",
             name, c, g[14:11], e[14:11], g[10:4], e[10:4], g[3], e[3], g[2:1], e[2:1], g[0], e[0]);
  endtask

  // Called at the sample point of cycle 0 of a frame; returns at cycle 0 of the next one.
  task automatic check_frame(input string name, input logic [15:0] cur_bcd,
                             input logic [3:0] cur_dp, input bit blz, input bit ft0,
                             input int ld_at, input int ld_len,
                             input logic [15:0] ld_bcd, input logic [3:0] ld_dp);
    logic [14:0] g, e;
    push_frame(cur_bcd, cur_dp, blz, ft0);
    for (int c = 0; c < FL; c++) begin
      g = got_vec();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        report_fail(name, c, g, e);
      end
      if (c == 0) bus.blank_lz = blz;
      if (c >= ld_at && c < ld_at + ld_len) begin
        bus.load = 1'b1;
        if (c == ld_at + ld_len - 1) begin
          bus.bcd_in = ld_bcd;
          bus.dp_in  = ld_dp;
        end else begin
          bus.bcd_in = 16'($urandom_range(0, 16'hFFFF));
          bus.dp_in  = 4'($urandom_range(0, 15));
        end
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    logic [14:0] g;
    g = got_vec();
    checks++;
    if (g !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      report_fail(name, -1, g, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    reset = 1'b0;
    @(negedge clk);
    check_frame("reset_idle", 16'h0000, 4'h0, 1'b0, 1'b0, 0, 0, 16'h0, 4'h0);
  endtask

  task automatic test_frame_sync_load();
    check_frame("fsync_old", 16'h0000, 4'h0, 1'b0, 1'b1, 6, 1, 16'h1234, 4'h0);
    check_frame("fsync_new", 16'h1234, 4'h0, 1'b0, 1'b1, 0, 0, 16'h0, 4'h0);
  endtask

  task automatic test_boundary_load();
    // Cycle 14 is the last state cycle of the frame: the load lands on the boundary edge.
    check_frame("bnd_load", 16'h1234, 4'h0, 1'b0, 1'b1, 14, 1, 16'h5678, 4'h0);
    check_frame("bnd_prev", 16'h1234, 4'h0, 1'b0, 1'b1, 0, 0, 16'h0, 4'h0);
    check_frame("bnd_new",  16'h5678, 4'h0, 1'b0, 1'b1, 0, 0, 16'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    check_frame("b2b_load", 16'h5678, 4'h0, 1'b0, 1'b1, 3, 3, 16'hA5B0, 4'b1010);
    check_frame("b2b_last", 16'hA5B0, 4'b1010, 1'b0, 1'b1, 0, 0, 16'h0, 4'h0);
  endtask

  task automatic test_lz();
    check_frame("lz_arm",  16'hA5B0, 4'b1010, 1'b1, 1'b1, 5, 1, 16'h0070, 4'h0);
    check_frame("lz_0070", 16'h0070, 4'h0,    1'b1, 1'b1, 2, 1, 16'h0000, 4'b0010);
    check_frame("lz_0000", 16'h0000, 4'b0010, 1'b1, 1'b1, 3, 1, 16'hFEDC, 4'b0100);
  endtask

  task automatic test_dp_hex();
    check_frame("dp_hex", 16'hFEDC, 4'b0100, 1'b0, 1'b1, 0, 0, 16'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    logic [14:0] g, e;
    push_frame(16'hFEDC, 4'b0100, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      g = got_vec();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        report_fail("rmid_pre", c, g, e);
      end
      if (c < 9) @(negedge clk);
    end
    exp_q.delete();
    #2 reset = 1'b1;
    #1 check_reset_vals("rmid_async");
    @(negedge clk);
    check_reset_vals("rmid_hold");
    reset = 1'b0;
    @(negedge clk);
    check_frame("rmid_restart", 16'h0000, 4'h0, 1'b0, 1'b0, 0, 0, 16'h0, 4'h0);
    check_frame("rmid_tick",    16'h0000, 4'h0, 1'b0, 1'b1, 0, 0, 16'h0, 4'h0);
  endtask

  initial begin
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    test_reset();
    test_frame_sync_load();
    test_boundary_load();
    test_back_to_back();
    test_lz();
    test_dp_hex();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
